// File: rtl/stream_ahb_master_pkg.sv
// Shared encodings for the byte-stream to AHB-Lite initiator.
package stream_ahb_master_pkg;

  // Default command opcodes
  localparam logic [7:0] OPC_WRITE_DEF = 8'h01;
  localparam logic [7:0] OPC_READ_DEF  = 8'h02;

  // Response status codes
  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_BUSERR   = 8'h01;
  localparam logic [7:0] ST_MISALIGN = 8'h02;
  localparam logic [7:0] ST_BADOP    = 8'hFF;

  // AHB-Lite encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD_ADDR,
    S_CMD_WDATA,
    S_BUS_ADDR,
    S_BUS_DATA,
    S_RSP
  } state_t;

endpackage

// File: rtl/stream_byte_shifter.sv
// 4-byte little-endian shift register: first byte lands in data[7:0].
module stream_byte_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  din,
  output logic [31:0] data,
  output logic        done
);

  logic [1:0] cnt;

  // done flags the shift that brings in the fourth byte
  assign done = shift && (cnt == 2'd3);

  // Bytes enter at the top so the earliest byte ends at the bottom
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      cnt  <= '0;
    end else if (clr) begin
      cnt  <= '0;
    end else if (shift) begin
      data <= {din, data[31:8]};
      cnt  <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/stream_ahb_master.sv
// Byte-stream command parser driving single-word AHB-Lite transfers,
// answering each frame with a status byte (plus read data).
module stream_ahb_master
  import stream_ahb_master_pkg::*;
#(
  parameter logic [7:0] OPC_WRITE = OPC_WRITE_DEF,
  parameter logic [7:0] OPC_READ  = OPC_READ_DEF,
  parameter bit         WR_RSP    = 1'b1
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        in_tvalid,
  output logic        in_tready,
  input  logic [7:0]  in_tdata,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic [7:0]  out_tdata,
  output logic        out_tlast,
  output logic [31:0] haddrm,
  output logic [1:0]  htransm,
  output logic        hwritem,
  output logic [2:0]  hsizem,
  output logic [2:0]  hburstm,
  output logic [31:0] hwdatam,
  input  logic        hreadym,
  input  logic        hrespm,
  input  logic [31:0] hrdatam,
  output logic        busy
);

  state_t      state, state_nxt;
  logic        rst_done;
  logic        is_write;
  logic        misal;
  logic [7:0]  status;
  logic [31:0] rdata;
  logic [2:0]  idx;
  logic [2:0]  last_idx;

  logic        in_fire, out_fire;
  logic        addr_done, wd_done, opc_ok, addr_mis;
  logic [31:0] addr_data, wd_data;

  assign in_fire  = in_tvalid && in_tready;
  assign out_fire = out_tvalid && out_tready;
  assign opc_ok   = (in_tdata == OPC_READ) || (in_tdata == OPC_WRITE);
  // On the fourth address byte, A0 sits in bits 15:8 before the final shift
  assign addr_mis = (addr_data[9:8] != 2'b00);
  assign last_idx = (status == ST_OK && !is_write) ? 3'd4 : 3'd0;

  stream_byte_shifter u_addr (
    .clk   (hclk),
    .rst_n (hresetn),
    .clr   (in_fire && state == S_IDLE),
    .shift (in_fire && state == S_CMD_ADDR),
    .din   (in_tdata),
    .data  (addr_data),
    .done  (addr_done)
  );

  stream_byte_shifter u_wdata (
    .clk   (hclk),
    .rst_n (hresetn),
    .clr   (in_fire && state == S_IDLE),
    .shift (in_fire && state == S_CMD_WDATA),
    .din   (in_tdata),
    .data  (wd_data),
    .done  (wd_done)
  );

  // Shifters hold their contents outside the command states, so they
  // double as the address and write-data registers of the bus transfer
  assign haddrm  = addr_data;
  assign hwdatam = wd_data;
  assign hsizem  = HSIZE_WORD;
  assign hburstm = HBURST_SINGLE;

  // Keeps in_tready low while reset is asserted and for one cycle after
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) rst_done <= 1'b0;
    else          rst_done <= 1'b1;
  end

  // State register
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (in_fire) state_nxt = opc_ok ? S_CMD_ADDR : S_RSP;
      S_CMD_ADDR:  if (addr_done)
                     state_nxt = is_write ? S_CMD_WDATA : (addr_mis ? S_RSP : S_BUS_ADDR);
      S_CMD_WDATA: if (wd_done) state_nxt = misal ? S_RSP : S_BUS_ADDR;
      S_BUS_ADDR:  if (hreadym) state_nxt = S_BUS_DATA;
      S_BUS_DATA:  if (hreadym)
                     state_nxt = (is_write && !hrespm && !WR_RSP) ? S_IDLE : S_RSP;
      S_RSP:       if (out_fire && idx == last_idx) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Frame bookkeeping: direction, misalignment, status, read data, byte index
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      is_write <= 1'b0;
      misal    <= 1'b0;
      status   <= ST_OK;
      rdata    <= '0;
      idx      <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_fire) begin
          is_write <= (in_tdata == OPC_WRITE);
          misal    <= 1'b0;
          idx      <= '0;
          if (!opc_ok) status <= ST_BADOP;
        end
        S_CMD_ADDR: if (addr_done) begin
          misal <= addr_mis;
          if (addr_mis && !is_write) status <= ST_MISALIGN;
        end
        S_CMD_WDATA: if (wd_done && misal) status <= ST_MISALIGN;
        S_BUS_DATA: if (hreadym) begin
          status <= hrespm ? ST_BUSERR : ST_OK;
          if (!is_write) rdata <= hrdatam;
        end
        S_RSP: if (out_fire) idx <= (idx == last_idx) ? 3'd0 : idx + 3'd1;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and the held response registers
  always_comb begin
    in_tready  = 1'b0;
    out_tvalid = 1'b0;
    out_tdata  = 8'h00;
    out_tlast  = 1'b0;
    htransm    = HTRANS_IDLE;
    hwritem    = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE, S_CMD_ADDR, S_CMD_WDATA: in_tready = rst_done;
      S_BUS_ADDR: begin
        htransm = HTRANS_NONSEQ;
        hwritem = is_write;
      end
      S_RSP: begin
        out_tvalid = 1'b1;
        out_tlast  = (idx == last_idx);
        case (idx)
          3'd0:    out_tdata = status;
          3'd1:    out_tdata = rdata[7:0];
          3'd2:    out_tdata = rdata[15:8];
          3'd3:    out_tdata = rdata[23:16];
          3'd4:    out_tdata = rdata[31:24];
          default: out_tdata = 8'h00;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stream_ahb_master.sv
// Directed bench: command frames in, hand-computed bus activity and responses out.
module tb_stream_ahb_master;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        in_tvalid = 1'b0;
  logic        in_tready;
  logic [7:0]  in_tdata = 8'h00;
  logic        out_tvalid;
  logic        out_tready = 1'b1;
  logic [7:0]  out_tdata;
  logic        out_tlast;
  logic [31:0] haddrm;
  logic [1:0]  htransm;
  logic        hwritem;
  logic [2:0]  hsizem;
  logic [2:0]  hburstm;
  logic [31:0] hwdatam;
  logic        hreadym = 1'b1;
  logic        hrespm = 1'b0;
  logic [31:0] hrdatam = 32'h0;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;
  int ns_cnt = 0;
  bit tog = 1'b0;

  always #5 hclk = ~hclk;

  // Counts every cycle a NONSEQ is presented on the bus
  always @(posedge hclk) if (htransm == 2'b10) ns_cnt <= ns_cnt + 1;

  stream_ahb_master dut (
    .hclk(hclk), .hresetn(hresetn),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
    .out_tlast(out_tlast),
    .haddrm(haddrm), .htransm(htransm), .hwritem(hwritem), .hsizem(hsizem),
    .hburstm(hburstm), .hwdatam(hwdatam), .hreadym(hreadym), .hrespm(hrespm),
    .hrdatam(hrdatam), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk); #1;
  endtask

  // Send n bytes; byte i is f[8*i+:8]
  task automatic send_frame(input int n, input logic [71:0] f);
    for (int i = 0; i < n; i++) begin
      int cyc = 0;
      in_tvalid = 1'b1;
      in_tdata  = f[8*i +: 8];
      while (!in_tready && cyc < 20) begin tick(); cyc++; end
      if (!in_tready) begin
        chk("in_tready_timeout", 32'd0, 32'd1);
        in_tvalid = 1'b0;
        return;
      end
      tick();
    end
    in_tvalid = 1'b0;
  endtask

  // Called the cycle after the last command byte: address phase must be up
  task automatic serve(input string tag, input logic [31:0] addr, input bit wr,
                       input logic [31:0] wd, input int ws, input bit err,
                       input logic [31:0] rd);
    chk({tag, "_nonseq"}, {30'h0, htransm}, 32'h2);
    chk({tag, "_haddr"}, haddrm, addr);
    chk({tag, "_hwrite"}, {31'h0, hwritem}, {31'h0, wr});
    chk({tag, "_hsize"}, {29'h0, hsizem}, 32'h2);
    chk({tag, "_hburst"}, {29'h0, hburstm}, 32'h0);
    tick();
    chk({tag, "_trans_idle"}, {30'h0, htransm}, 32'h0);
    for (int i = 0; i < ws; i++) begin
      hreadym = 1'b0;
      if (wr) chk({tag, "_hwdata_ws"}, hwdatam, wd);
      tick();
    end
    if (err) begin
      hreadym = 1'b0; hrespm = 1'b1;
      tick();
    end
    hreadym = 1'b1; hrespm = err; hrdatam = rd;
    if (wr) chk({tag, "_hwdata"}, hwdatam, wd);
    tick();
    hrespm = 1'b0; hrdatam = 32'h0;
  endtask

  // Collect n response bytes; exp byte i is exp[8*i+:8]
  task automatic get_rsp(input string tag, input int n, input logic [39:0] exp, input bit bp);
    for (int i = 0; i < n; i++) begin
      int cyc = 0;
      bit got = 1'b0;
      bit stalled = 1'b0;
      logic [7:0] held = 8'h00;
      while (!got && cyc < 40) begin
        out_tready = bp ? tog : 1'b1;
        tog = ~tog;
        if (out_tvalid && out_tready) got = 1'b1;
        else begin
          if (out_tvalid) begin
            if (stalled) chk({tag, "_hold"}, {24'h0, out_tdata}, {24'h0, held});
            stalled = 1'b1;
            held = out_tdata;
          end
          tick();
          cyc++;
        end
      end
      if (!got) begin
        chk({tag, "_rsp_timeout"}, 32'd0, 32'd1);
        out_tready = 1'b1;
        return;
      end
      if (stalled) chk($sformatf("%s_stable%0d", tag, i), {24'h0, out_tdata}, {24'h0, held});
      chk($sformatf("%s_byte%0d", tag, i), {24'h0, out_tdata}, {24'h0, exp[8*i +: 8]});
      chk($sformatf("%s_tlast%0d", tag, i), {31'h0, out_tlast}, {31'h0, (i == n - 1)});
      chk($sformatf("%s_in_rdy%0d", tag, i), {31'h0, in_tready}, 32'h0);
      tick();
    end
    out_tready = 1'b1;
    chk({tag, "_done_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_done_tvalid"}, {31'h0, out_tvalid}, 32'h0);
  endtask

  initial begin
    int ns0;

    // Reset state
    repeat (2) tick();
    chk("rst_in_tready", {31'h0, in_tready}, 32'h0);
    chk("rst_out_tvalid", {31'h0, out_tvalid}, 32'h0);
    chk("rst_out_tlast", {31'h0, out_tlast}, 32'h0);
    chk("rst_out_tdata", {24'h0, out_tdata}, 32'h0);
    chk("rst_htrans", {30'h0, htransm}, 32'h0);
    chk("rst_haddr", haddrm, 32'h0);
    chk("rst_hwrite", {31'h0, hwritem}, 32'h0);
    chk("rst_hwdata", hwdatam, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    hresetn = 1'b1;
    tick();

    // Read, zero wait states: 02 00 00 00 81
    send_frame(5, 72'h81_00_00_00_02);
    serve("rd0", 32'h8100_0000, 1'b0, 32'h0, 0, 1'b0, 32'hDEAD_BEEF);
    get_rsp("rd0", 5, 40'hDE_AD_BE_EF_00, 1'b0);

    // Write, 3 wait states: 01 10 00 00 80 78 56 34 12
    send_frame(9, 72'h12_34_56_78_80_00_00_10_01);
    serve("wr3", 32'h8000_0010, 1'b1, 32'h1234_5678, 3, 1'b0, 32'h0);
    get_rsp("wr3", 1, 40'h00, 1'b0);

    // Two-cycle ERROR response on a read
    send_frame(5, 72'h80_00_00_20_02);
    serve("rderr", 32'h8000_0020, 1'b0, 32'h0, 1, 1'b1, 32'h5555_AAAA);
    get_rsp("rderr", 1, 40'h01, 1'b0);

    // Misaligned write: data bytes still consumed, no bus transfer
    ns0 = ns_cnt;
    send_frame(9, 72'h44_33_22_11_80_00_00_02_01);
    get_rsp("miswr", 1, 40'h02, 1'b0);
    chk("miswr_no_nonseq", ns_cnt, ns0);

    // Misaligned read
    send_frame(5, 72'h80_00_00_03_02);
    get_rsp("misrd", 1, 40'h02, 1'b0);
    chk("misrd_no_nonseq", ns_cnt, ns0);

    // Bad opcode, then a normal frame
    send_frame(1, 72'h07);
    get_rsp("badop", 1, 40'hFF, 1'b0);
    chk("badop_no_nonseq", ns_cnt, ns0);
    send_frame(5, 72'h80_00_00_04_02);
    serve("rd1", 32'h8000_0004, 1'b0, 32'h0, 2, 1'b0, 32'h0102_0304);
    get_rsp("rd1", 5, 40'h01_02_03_04_00, 1'b0);

    // Back-pressure on a read response
    send_frame(5, 72'h80_00_00_08_02);
    serve("bp", 32'h8000_0008, 1'b0, 32'h0, 0, 1'b0, 32'hCAFE_F00D);
    tog = 1'b0;
    get_rsp("bp", 5, 40'hCA_FE_F0_0D_00, 1'b1);

    // Reset during the data phase
    send_frame(5, 72'h80_00_00_0C_02);
    chk("rst_mid_nonseq", {30'h0, htransm}, 32'h2);
    tick();
    hreadym = 1'b0;
    tick();
    chk("rst_mid_busy", {31'h0, busy}, 32'h1);
    hresetn = 1'b0;
    #1;
    chk("rst_mid_htrans", {30'h0, htransm}, 32'h0);
    chk("rst_mid_tvalid", {31'h0, out_tvalid}, 32'h0);
    chk("rst_mid_in_rdy", {31'h0, in_tready}, 32'h0);
    chk("rst_mid_idle", {31'h0, busy}, 32'h0);
    hreadym = 1'b1;
    repeat (2) tick();
    hresetn = 1'b1;
    tick();
    send_frame(5, 72'h80_00_01_00_02);
    serve("rd2", 32'h8000_0100, 1'b0, 32'h0, 0, 1'b0, 32'h8765_4321);
    get_rsp("rd2", 5, 40'h87_65_43_21_00, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
